// File: rtl/lvds_rx_iq_framer_pkg.sv
// Shared constants and FSM encoding for the LVDS I/Q symbol framer.
// Build option LVDS_RX_FRAMER_STATS_EN (see top) adds statistics counters.
package lvds_rx_iq_framer_pkg;

  localparam logic [1:0] I_SYNC     = 2'b10;
  localparam logic [1:0] Q_SYNC     = 2'b01;
  localparam int         SYM_W      = 2;
  localparam int         FRAME_SYMS = 7;
  localparam int         BODY_W     = SYM_W * FRAME_SYMS;
  localparam logic [2:0] LAST_SYM   = 3'(FRAME_SYMS - 1);

  typedef enum logic [2:0] {
    ST_HUNT       = 3'd0,
    ST_I_BODY     = 3'd1,
    ST_Q_SYNC_CHK = 3'd2,
    ST_Q_BODY     = 3'd3,
    ST_I_SYNC_CHK = 3'd4
  } framer_state_e;

endpackage

// File: rtl/lvds_rx_sym_shifter.sv
// Seven-symbol shift register; first received symbol ends up in the MSBs.
module lvds_rx_sym_shifter
  import lvds_rx_iq_framer_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_b_i,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic [SYM_W-1:0]  sym_i,
  output logic [BODY_W-1:0] data_o
);

  logic [BODY_W-1:0] data_q;
  logic [BODY_W-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (clear_i) begin
      data_d = '0;
    end else if (load_i) begin
      data_d = {data_q[BODY_W-SYM_W-1:0], sym_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_b_i) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/lvds_rx_iq_framer.sv
// Frames 2-bit modem symbols into I/Q sample words and writes them as a pair.
// Define LVDS_RX_FRAMER_STATS_EN to add frame/drop/sync-error counters.
module lvds_rx_iq_framer
  import lvds_rx_iq_framer_pkg::*;
#(
  parameter int DATA_WIDTH      = 16,
  parameter int SYNC_LOSS_LIMIT = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_b_i,
  input  logic                  sym_valid_i,
  input  logic [1:0]            sym_i,
  input  logic                  fifo_full_i,
  output logic                  fifo_wr_en_o,
  output logic [DATA_WIDTH-1:0] fifo_data_o,
  output logic                  locked_o,
  output logic                  drop_o,
  output logic                  sync_err_o
`ifdef LVDS_RX_FRAMER_STATS_EN
  ,
  output logic [31:0]           frame_cnt_o,
  output logic [15:0]           drop_cnt_o,
  output logic [15:0]           sync_err_cnt_o
`endif
);

  localparam int              ERR_W    = $clog2(SYNC_LOSS_LIMIT + 1);
  localparam logic [ERR_W-1:0] ERR_LAST = ERR_W'(SYNC_LOSS_LIMIT - 1);
  localparam logic [ERR_W-1:0] ERR_SAT  = ERR_W'(SYNC_LOSS_LIMIT);

  framer_state_e     state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              i_load, i_clear, q_load, q_clear;
  logic              frame_done, sync_err;
  logic [BODY_W-1:0] i_data, q_data;

  // Handshake: the FIFO is written on every cycle fifo_wr_en_o is high; a
  // pair is only started when fifo_full_i is low in its I-word cycle, after
  // which the Q word two cycles later is committed unconditionally.
  logic              ph1_q, ph2_q, ph3_q;
  logic              wr_i, wr_q;
  logic [BODY_W-1:0] q_hold_q;
  logic [DATA_WIDTH-1:0] data_last_q;

  logic              locked_q, locked_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
  logic              sync_err_q;

  lvds_rx_sym_shifter u_i_shift (
    .clk_i   (clk_i),
    .rst_b_i (rst_b_i),
    .clear_i (i_clear),
    .load_i  (i_load),
    .sym_i   (sym_i),
    .data_o  (i_data)
  );

  lvds_rx_sym_shifter u_q_shift (
    .clk_i   (clk_i),
    .rst_b_i (rst_b_i),
    .clear_i (q_clear),
    .load_i  (q_load),
    .sym_i   (sym_i),
    .data_o  (q_data)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    i_load     = 1'b0;
    i_clear    = 1'b0;
    q_load     = 1'b0;
    q_clear    = 1'b0;
    frame_done = 1'b0;
    sync_err   = 1'b0;
    if (sym_valid_i) begin
      case (state_q)
        ST_HUNT: begin
          if (sym_i == I_SYNC) begin
            state_d = ST_I_BODY;
            cnt_d   = '0;
            i_clear = 1'b1;
          end
        end
        ST_I_BODY: begin
          i_load = 1'b1;
          if (cnt_q == LAST_SYM) begin
            cnt_d   = '0;
            state_d = ST_Q_SYNC_CHK;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        ST_Q_SYNC_CHK: begin
          if (sym_i == Q_SYNC) begin
            state_d = ST_Q_BODY;
            cnt_d   = '0;
            q_clear = 1'b1;
          end else begin
            sync_err = 1'b1;
            state_d  = ST_HUNT;
          end
        end
        ST_Q_BODY: begin
          q_load = 1'b1;
          if (cnt_q == LAST_SYM) begin
            cnt_d      = '0;
            frame_done = 1'b1;
            state_d    = ST_I_SYNC_CHK;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        ST_I_SYNC_CHK: begin
          if (sym_i == I_SYNC) begin
            state_d = ST_I_BODY;
            cnt_d   = '0;
            i_clear = 1'b1;
          end else begin
            sync_err = 1'b1;
            state_d  = ST_HUNT;
          end
        end
        default: begin
          state_d = ST_HUNT;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // The I shifter cannot change before the cycle after the I write, so the
  // I word is read straight from it; the Q body is snapshotted for later.
  assign wr_i = ph1_q & ~fifo_full_i;
  assign wr_q = ph3_q;

  always_comb begin
    fifo_data_o = data_last_q;
    if (wr_i) begin
      fifo_data_o = DATA_WIDTH'({I_SYNC, i_data});
    end else if (wr_q) begin
      fifo_data_o = DATA_WIDTH'({Q_SYNC, q_hold_q});
    end
  end

  assign fifo_wr_en_o = wr_i | wr_q;
  assign drop_o       = ph1_q & fifo_full_i;

  always_comb begin
    locked_d  = locked_q;
    err_cnt_d = err_cnt_q;
    if (frame_done) begin
      locked_d  = 1'b1;
      err_cnt_d = '0;
    end else if (sync_err) begin
      if (err_cnt_q >= ERR_LAST) begin
        locked_d  = 1'b0;
        err_cnt_d = ERR_SAT;
      end else begin
        err_cnt_d = err_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_b_i) begin
      state_q     <= ST_HUNT;
      cnt_q       <= '0;
      ph1_q       <= 1'b0;
      ph2_q       <= 1'b0;
      ph3_q       <= 1'b0;
      q_hold_q    <= '0;
      data_last_q <= '0;
      locked_q    <= 1'b0;
      err_cnt_q   <= '0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ph1_q      <= frame_done;
      ph2_q      <= wr_i;
      ph3_q      <= ph2_q;
      locked_q   <= locked_d;
      err_cnt_q  <= err_cnt_d;
      sync_err_q <= sync_err;
      if (ph1_q) begin
        q_hold_q <= q_data;
      end
      if (fifo_wr_en_o) begin
        data_last_q <= fifo_data_o;
      end
    end
  end

  assign locked_o   = locked_q;
  assign sync_err_o = sync_err_q;

`ifdef LVDS_RX_FRAMER_STATS_EN
  logic [31:0] frame_cnt_q;
  logic [15:0] drop_cnt_q;
  logic [15:0] sync_err_cnt_q;

  // Counters wrap naturally at their maximum.
  always_ff @(posedge clk_i) begin
    if (!rst_b_i) begin
      frame_cnt_q    <= '0;
      drop_cnt_q     <= '0;
      sync_err_cnt_q <= '0;
    end else begin
      if (wr_i)       frame_cnt_q    <= frame_cnt_q + 32'd1;
      if (drop_o)     drop_cnt_q     <= drop_cnt_q + 16'd1;
      if (sync_err_q) sync_err_cnt_q <= sync_err_cnt_q + 16'd1;
    end
  end

  assign frame_cnt_o    = frame_cnt_q;
  assign drop_cnt_o     = drop_cnt_q;
  assign sync_err_cnt_o = sync_err_cnt_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_lvds_rx_iq_framer.sv
// Directed bench for lvds_rx_iq_framer with a queue-based write/pulse scoreboard.
module tb_lvds_rx_iq_framer;

  logic        clk_i = 1'b0;
  logic        rst_b_i = 1'b0;
  logic        sym_valid_i = 1'b0;
  logic [1:0]  sym_i = 2'b00;
  logic        fifo_full_i = 1'b0;
  logic        fifo_wr_en_o;
  logic [15:0] fifo_data_o;
  logic        locked_o;
  logic        drop_o;
  logic        sync_err_o;
`ifdef LVDS_RX_FRAMER_STATS_EN
  logic [31:0] frame_cnt_o;
  logic [15:0] drop_cnt_o;
  logic [15:0] sync_err_cnt_o;
`endif

  lvds_rx_iq_framer #(.DATA_WIDTH(16), .SYNC_LOSS_LIMIT(3)) dut (
    .clk_i          (clk_i),
    .rst_b_i        (rst_b_i),
    .sym_valid_i    (sym_valid_i),
    .sym_i          (sym_i),
    .fifo_full_i    (fifo_full_i),
    .fifo_wr_en_o   (fifo_wr_en_o),
    .fifo_data_o    (fifo_data_o),
    .locked_o       (locked_o),
    .drop_o         (drop_o),
    .sync_err_o     (sync_err_o)
`ifdef LVDS_RX_FRAMER_STATS_EN
    ,
    .frame_cnt_o    (frame_cnt_o),
    .drop_cnt_o     (drop_cnt_o),
    .sync_err_cnt_o (sync_err_cnt_o)
`endif
  );

  // Clock and cycle index
  always #5 clk_i = ~clk_i;
  int cyc = 0;
  always @(posedge clk_i) cyc++;

  // Scoreboard state
  logic [15:0] exp_q[$];
  int          exp_t_q[$];
  int          drop_t_q[$];
  int          serr_t_q[$];
  int          total = 0;
  int          bad = 0;
  int          full_at = -1;
  int          rst_at = -1;
  int          exp_frames = 0;
  int          exp_drops = 0;
  int          exp_serrs = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Driver tasks
  task automatic send_sym(input logic v, input logic [1:0] s);
    @(posedge clk_i);
    #1;
    sym_valid_i = v;
    sym_i       = s;
    fifo_full_i = (cyc == full_at);
    rst_b_i     = !(cyc == rst_at);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) send_sym(1'b0, 2'b00);
  endtask

  // mode: 0 normal, 1 full at N+1, 2 full at N+3, 3 reset between I and Q
  task automatic send_frame(input logic [13:0] iw, input logic [13:0] qw,
                            input logic [1:0] qs, input int mode, input bit toggle);
    logic [1:0] syms[16];
    int c;
    syms[0] = 2'b10;
    syms[8] = qs;
    for (int k = 0; k < 7; k++) begin
      syms[1+k] = iw[13-2*k -: 2];
      syms[9+k] = qw[13-2*k -: 2];
    end
    for (int j = 0; j < 16; j++) begin
      if (toggle) send_sym(1'b0, 2'b10);
      send_sym(1'b1, syms[j]);
      if (j == 8 && qs != 2'b01) begin
        serr_t_q.push_back(cyc + 1);
        exp_serrs++;
      end
    end
    c = cyc;
    if (qs == 2'b01) begin
      case (mode)
        1: begin
          full_at = c + 1;
          drop_t_q.push_back(c + 1);
          exp_drops++;
        end
        3: begin
          rst_at = c + 1;
          exp_q.push_back({2'b10, iw});
          exp_t_q.push_back(c + 1);
          exp_frames++;
        end
        default: begin
          if (mode == 2) full_at = c + 3;
          exp_q.push_back({2'b10, iw});
          exp_t_q.push_back(c + 1);
          exp_q.push_back({2'b01, qw});
          exp_t_q.push_back(c + 3);
          exp_frames++;
        end
      endcase
    end
  endtask

  // Monitor: pops the expected queues whenever the DUT presents an event
  always @(negedge clk_i) begin
    if (fifo_wr_en_o) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL wr_unexpected data=%0h (cycle %0d)", fifo_data_o, cyc);
      end else begin
        check("wr_data", 32'(fifo_data_o), 32'(exp_q.pop_front()));
        check("wr_cycle", cyc, exp_t_q.pop_front());
      end
    end
    if (drop_o) begin
      if (drop_t_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL drop_unexpected (cycle %0d)", cyc);
      end else begin
        check("drop_cycle", cyc, drop_t_q.pop_front());
      end
    end
    if (sync_err_o) begin
      if (serr_t_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sync_err_unexpected (cycle %0d)", cyc);
      end else begin
        check("sync_err_cycle", cyc, serr_t_q.pop_front());
      end
    end
  end

  initial begin
    // Reset block
    rst_b_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_wr_en", 32'(fifo_wr_en_o), 0);
    check("rst_data", 32'(fifo_data_o), 0);
    check("rst_locked", 32'(locked_o), 0);
    check("rst_drop", 32'(drop_o), 0);
    check("rst_sync_err", 32'(sync_err_o), 0);
    idle(2);

    // Three back-to-back frames
    send_frame(14'h1234, 14'h0ABC, 2'b01, 0, 1'b0);
    send_frame(14'h1234, 14'h0ABC, 2'b01, 0, 1'b0);
    check("locked_after_first", 32'(locked_o), 1);
    send_frame(14'h1234, 14'h0ABC, 2'b01, 0, 1'b0);
    idle(6);
    @(negedge clk_i);
    check("data_hold", 32'(fifo_data_o), 32'h4ABC);

    // Bad Q sync, then recovery with a different payload
    send_frame(14'h1234, 14'h0000, 2'b11, 0, 1'b0);
    check("locked_one_err", 32'(locked_o), 1);
    idle(3);
    send_frame(14'h3FFF, 14'h0001, 2'b01, 0, 1'b0);
    idle(6);

    // FIFO full during the I slot drops the pair; full during the Q slot does not
    send_frame(14'h2AAA, 14'h1555, 2'b01, 1, 1'b0);
    idle(6);
    send_frame(14'h0F0F, 14'h30C3, 2'b01, 2, 1'b0);
    idle(6);

    // Gapped symbol stream
    send_frame(14'h1234, 14'h0ABC, 2'b01, 0, 1'b1);
    idle(6);

    // Three consecutive sync errors drop lock
    check("locked_before_loss", 32'(locked_o), 1);
    send_frame(14'h0001, 14'h0000, 2'b00, 0, 1'b0);
    send_frame(14'h0002, 14'h0000, 2'b11, 0, 1'b0);
    check("locked_two_errs", 32'(locked_o), 1);
    send_frame(14'h0003, 14'h0000, 2'b10, 0, 1'b0);
    check("locked_lost", 32'(locked_o), 0);
    idle(4);

`ifdef LVDS_RX_FRAMER_STATS_EN
    check("stat_frames", frame_cnt_o, exp_frames);
    check("stat_drops", 32'(drop_cnt_o), exp_drops);
    check("stat_sync_errs", 32'(sync_err_cnt_o), exp_serrs);
`endif

    // Reset between the I and Q writes suppresses the Q word
    send_frame(14'h1234, 14'h0ABC, 2'b01, 3, 1'b0);
    idle(8);
    @(negedge clk_i);
    check("locked_after_reset", 32'(locked_o), 0);
`ifdef LVDS_RX_FRAMER_STATS_EN
    check("stat_frames_reset", frame_cnt_o, 0);
`endif

    // Final report
    check("wr_queue_empty", exp_q.size(), 0);
    check("drop_queue_empty", drop_t_q.size(), 0);
    check("sync_err_queue_empty", serr_t_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
